// File: rtl/alu_rsp_pkg.sv
// Shared types and constants for the ALU response serializer.
// Holds the frame FSM state encoding and the byte-select indices.
// Imported by the queue and the serializer top.
package alu_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_LO  = 2'd1,
        SEND_HI  = 2'd2,
        SEND_CHK = 2'd3
    } state_t;

    localparam int LO_IDX = 0;
    localparam int HI_IDX = 1;

endpackage

// File: rtl/alu_rsp_serializer_if.sv
// ALU result input plus byte-wide TX stream and status, bundled as one interface.
// No latency of its own; wires only.
// Backpressure travels on TX_READY; the result side has none.
interface alu_rsp_if #(
    parameter int OUT_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8
);
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  OUT_VALID;
    logic [BYTE_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic                  BUSY;
    logic                  OVF_ERR;

    // Serializer side
    modport slave (
        input  ALU_OUT, OUT_VALID, TX_READY,
        output TX_DATA, TX_VALID, BUSY, OVF_ERR
    );

    // Environment side: ALU producer and TX FIFO consumer
    modport master (
        output ALU_OUT, OUT_VALID, TX_READY,
        input  TX_DATA, TX_VALID, BUSY, OVF_ERR
    );
endinterface

// File: rtl/alu_rsp_serializer_rsp_queue.sv
// Small result FIFO: synchronous write, combinational head read.
// Push visible at head one cycle after the write edge.
// Caller must not push when full unless popping on the same edge.
module rsp_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage write; when full with a same-edge pop the write lands in the slot being vacated
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_rsp_serializer.sv
// Queues ALU result words and emits each as LO,HI (plus LO^HI when RSP_CHECKSUM_EN) bytes.
// First byte valid one cycle after capture; back-to-back frames with no idle bubble.
// TX_READY low holds the current byte; results arriving to a full queue are dropped and flagged.
module alu_rsp_serializer
    import alu_rsp_pkg::*;
#(
    parameter int OUT_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int Q_DEPTH    = 2,
    localparam int CNT_W     = $clog2(Q_DEPTH) + 1
) (
    input  logic      CLK,
    input  logic      RST,
    alu_rsp_if.slave  bus
);

    state_t                state;
    state_t                next_state;
    logic [OUT_WIDTH-1:0]  head;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  hs;
    logic                  last_byte;
    logic                  pop;
    logic                  push;
    logic                  more;
    logic                  ovf;
    logic [BYTE_WIDTH-1:0] lo_byte;
    logic [BYTE_WIDTH-1:0] hi_byte;
    logic [BYTE_WIDTH-1:0] tx_byte;

    assign lo_byte = head[LO_IDX*BYTE_WIDTH +: BYTE_WIDTH];
    assign hi_byte = head[HI_IDX*BYTE_WIDTH +: BYTE_WIDTH];

    assign hs = bus.TX_VALID && bus.TX_READY;
`ifdef RSP_CHECKSUM_EN
    assign last_byte = (state == SEND_CHK);
`else
    assign last_byte = (state == SEND_HI);
`endif
    // The head entry retires only when the final byte of its frame is taken
    assign pop  = hs && last_byte;
    assign push = bus.OUT_VALID && (!full || pop);
    // Entries left after this pop, counting a word written on the same edge
    assign more = (count > CNT_W'(1)) || push;

    rsp_queue #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (push),
        .push_data (bus.ALU_OUT),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Frame state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // Frame sequencing: advance one byte per handshake, start the next frame without idling
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = SEND_LO;
            SEND_LO: if (hs) next_state = SEND_HI;
`ifdef RSP_CHECKSUM_EN
            SEND_HI:  if (hs) next_state = SEND_CHK;
            SEND_CHK: if (hs) next_state = more ? SEND_LO : IDLE;
`else
            SEND_HI:  if (hs) next_state = more ? SEND_LO : IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Byte select for the current frame position; zero when idle
    always_comb begin
        tx_byte = '0;
        case (state)
            SEND_LO:  tx_byte = lo_byte;
            SEND_HI:  tx_byte = hi_byte;
`ifdef RSP_CHECKSUM_EN
            SEND_CHK: tx_byte = lo_byte ^ hi_byte;
`endif
            default:  tx_byte = '0;
        endcase
    end

    // Dropped-result flag, registered so it pulses in the cycle after the drop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ovf <= 1'b0;
        else      ovf <= bus.OUT_VALID && !push;
    end

    assign bus.TX_DATA  = tx_byte;
    assign bus.TX_VALID = (state != IDLE);
    assign bus.BUSY     = !empty || (state != IDLE);
    assign bus.OVF_ERR  = ovf;

endmodule

// File: doc/alu_rsp_serializer.md
Name: alu_rsp_serializer

Overview:
Consumer end of the ALU result interface. Captures each registered result word (ALU_OUT / OUT_VALID pulse from the compare, arithmetic and logic units) into a 2-entry queue. Serializes each word, low byte first, onto a byte-wide valid/ready stream that feeds the UART TX FIFO write side. The upstream side has no backpressure, so overflow is detected and flagged rather than stalled.

Parameters:
OUT_WIDTH, 16, width of ALU result word; must equal 2*BYTE_WIDTH
BYTE_WIDTH, 8, width of downstream byte stream
Q_DEPTH, 2, result queue entries (power of 2, >=2)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
ALU_OUT  input  OUT_WIDTH  result word from ALU output register
OUT_VALID  input  1  one-cycle qualifier for ALU_OUT
TX_DATA  output  BYTE_WIDTH  byte to downstream FIFO
TX_VALID  output  1  TX_DATA valid
TX_READY  input  1  downstream can accept byte
BUSY  output  1  queue non-empty or frame in progress
OVF_ERR  output  1  one-cycle pulse: result dropped because queue was full

Behaviour:
- Reset (async, RST low): queue empty, pointers/count 0, FSM IDLE. TX_DATA=0, TX_VALID=0, BUSY=0, OVF_ERR=0. Reset mid-frame discards the partial frame and all queued words; no byte is re-sent.
- Push: at posedge with OUT_VALID=1, ALU_OUT is written if count<Q_DEPTH, or if count==Q_DEPTH and a pop occurs on the same edge.
- Overflow: otherwise the word is dropped, queue is unchanged, and OVF_ERR=1 for the following cycle (registered).
- FSM states: IDLE, SEND_LO, SEND_HI.
  - IDLE -> SEND_LO when count>0.
  - SEND_LO -> SEND_HI on TX_VALID&&TX_READY.
  - SEND_HI on handshake pops the head entry. Next state is SEND_LO if entries remain after the pop (including a same-edge push), else IDLE.
- TX_VALID=1 exactly in SEND_LO and SEND_HI. TX_DATA = head[BYTE_WIDTH-1:0] in SEND_LO, head[OUT_WIDTH-1:BYTE_WIDTH] in SEND_HI, 0 in IDLE.
- While TX_VALID=1 and TX_READY=0, TX_DATA and TX_VALID hold stable; the head entry is never overwritten.
- Latency: OUT_VALID sampled at edge N into an empty queue with FSM IDLE -> TX_VALID high from edge N+1. Best case two bytes in 2 cycles, back-to-back words with no IDLE bubble.
- BUSY = (count!=0) || (state!=IDLE).
- TX_READY is ignored in IDLE. OUT_VALID is accepted in any state.
- Count arithmetic: count has log2(Q_DEPTH)+1 bits. Read/write pointers are log2(Q_DEPTH) bits and wrap naturally.

Optional Feature:
Macro RSP_CHECKSUM_EN.
- Defined: adds state SEND_CHK after SEND_HI. Each frame is 3 bytes: LO, HI, CHK = LO ^ HI.
  - SEND_HI handshake -> SEND_CHK; the pop occurs on the SEND_CHK handshake, with the same next-state rule.
- Undefined: 2-byte frames, no SEND_CHK state or logic.

Decomposition:
- Shared package alu_rsp_pkg: FSM state enum (IDLE, SEND_LO, SEND_HI, SEND_CHK) and the byte-select constants LO_IDX=0, HI_IDX=1.
- One sub-module: rsp_queue. Synchronous-write, combinational-read-head FIFO with push, pop, full, empty, count, holding the storage and pointers.
- The top contains the FSM, byte mux and OVF_ERR flop.

Test Plan:
- Reset then single word: OUT_VALID with ALU_OUT=16'h0003, TX_READY=1 -> bytes 8'h03, 8'h00 on consecutive cycles. BUSY falls after the second. Checksum build: 03, 00, 03.
- Backpressure: ALU_OUT=16'hA55A, TX_READY=0 for 5 cycles -> TX_DATA holds 8'h5A with TX_VALID=1. Release -> 5A then A5.
- Overflow: with TX_READY=0, push 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> third dropped, OVF_ERR pulses once. Release -> output 01,00,02,00 only.
- Full plus same-edge pop: queue full, OUT_VALID=1 coincident with the SEND_HI handshake -> word accepted, no OVF_ERR, back-to-back SEND_LO.
- Reset mid-frame: assert RST after LO byte of 16'h1234 accepted -> TX_VALID=0 immediately. After release, no 8'h12 emitted and BUSY=0.
- Random stress: 1000 random words with random OUT_VALID/TX_READY -> scoreboard byte stream equals LO/HI of accepted words in order. OVF_ERR count equals dropped words.
